// File: rtl/multicycle_control_if.sv
// Handshake/control bundle between the multi-cycle sequencer (master) and the
// instruction register / shared datapath / memory side (slave).
interface multicycle_control_if;
  logic [6:0] i_opcode;
  logic       i_mem_ready;
  logic       o_PCWrite;
  logic       o_IRWrite;
  logic       o_IorD;
  logic       o_Jump;
  logic       o_ALUSrc;
  logic       o_MemtoReg;
  logic       o_RegWrite;
  logic       o_MemRead;
  logic       o_MemWrite;
  logic       o_Branch;
  logic [1:0] o_ALUOp;
  logic [2:0] o_ImmSrc;
  logic [2:0] o_state;
  logic       o_instr_done;
  logic       o_illegal;

  modport master (
    input  i_opcode, i_mem_ready,
    output o_PCWrite, o_IRWrite, o_IorD, o_Jump, o_ALUSrc, o_MemtoReg,
           o_RegWrite, o_MemRead, o_MemWrite, o_Branch, o_ALUOp, o_ImmSrc,
           o_state, o_instr_done, o_illegal
  );

  modport slave (
    output i_opcode, i_mem_ready,
    input  o_PCWrite, o_IRWrite, o_IorD, o_Jump, o_ALUSrc, o_MemtoReg,
           o_RegWrite, o_MemRead, o_MemWrite, o_Branch, o_ALUOp, o_ImmSrc,
           o_state, o_instr_done, o_illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// RV32I multi-cycle sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with memory stall.
// Optional ILLEGAL_OP_EN: unknown opcodes halt the core and set a sticky o_illegal.
module multicycle_control (
  input  logic                   i_clk,
  input  logic                   i_rst,
  multicycle_control_if.master   bus
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_IARITH, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_AUIPC
  } class_t;

  state_t     state, state_next;
  logic [6:0] opcode_q;
  class_t     op_class;

  logic       cls_alu_src;
  logic [1:0] cls_alu_op;
  logic [2:0] cls_imm_src;

  logic       pc_write, ir_write, i_or_d, jump, alu_src, mem_to_reg;
  logic       reg_write, mem_read, mem_write, branch, instr_done;
  logic [1:0] alu_op;
  logic [2:0] imm_src;

`ifdef ILLEGAL_OP_EN
  logic illegal_q, illegal_set;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= FETCH;
      opcode_q <= '0;
`ifdef ILLEGAL_OP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (state == DECODE) opcode_q <= bus.i_opcode;
`ifdef ILLEGAL_OP_EN
      if (illegal_set) illegal_q <= 1'b1;
`endif
    end
  end

  always_comb begin
    case (opcode_q)
      7'b0110011: op_class = C_R;
      7'b0010011: op_class = C_IARITH;
      7'b0000011: op_class = C_LOAD;
      7'b0100011: op_class = C_STORE;
      7'b1100011: op_class = C_BRANCH;
      7'b1101111: op_class = C_JAL;
      7'b1100111: op_class = C_JALR;
      7'b0010111: op_class = C_AUIPC;
      default:    op_class = C_NONE;
    endcase
  end

  // ALU/immediate selection stays stable from EXECUTE through WRITEBACK.
  always_comb begin
    cls_alu_src = 1'b0;
    cls_alu_op  = 2'b00;
    cls_imm_src = 3'b000;
    case (op_class)
      C_R:      cls_alu_op = 2'b10;
      C_IARITH: begin cls_alu_src = 1'b1; cls_alu_op = 2'b10; end
      C_LOAD:   cls_alu_src = 1'b1;
      C_STORE:  begin cls_alu_src = 1'b1; cls_imm_src = 3'b001; end
      C_BRANCH: begin cls_alu_op = 2'b01; cls_imm_src = 3'b010; end
      C_JAL:    cls_imm_src = 3'b011;
      C_JALR:   cls_alu_src = 1'b1;
      C_AUIPC:  begin cls_alu_src = 1'b1; cls_imm_src = 3'b100; end
      default:  ;
    endcase
  end

  always_comb begin
    state_next = state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    jump       = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    alu_op     = 2'b00;
    imm_src    = 3'b000;
    instr_done = 1'b0;
`ifdef ILLEGAL_OP_EN
    illegal_set = 1'b0;
`endif
    case (state)
      FETCH: begin
        mem_read = 1'b1;
        if (bus.i_mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: state_next = EXECUTE;
      EXECUTE: begin
        alu_src = cls_alu_src;
        alu_op  = cls_alu_op;
        imm_src = cls_imm_src;
        branch  = (op_class == C_BRANCH);
        if (op_class == C_JAL || op_class == C_JALR) begin
          pc_write = 1'b1;
          jump     = 1'b1;
        end
        case (op_class)
          C_LOAD, C_STORE: state_next = MEM;
          C_BRANCH: begin
            instr_done = 1'b1;
            state_next = FETCH;
          end
          C_NONE: begin
`ifdef ILLEGAL_OP_EN
            illegal_set = 1'b1;
            state_next  = HALT;
`else
            instr_done = 1'b1;
            state_next = FETCH;
`endif
          end
          default: state_next = WRITEBACK;
        endcase
      end
      MEM: begin
        alu_src   = cls_alu_src;
        alu_op    = cls_alu_op;
        imm_src   = cls_imm_src;
        i_or_d    = 1'b1;
        mem_read  = (op_class == C_LOAD);
        mem_write = (op_class == C_STORE);
        if (bus.i_mem_ready) begin
          if (op_class == C_LOAD) begin
            state_next = WRITEBACK;
          end else begin
            instr_done = 1'b1;
            state_next = FETCH;
          end
        end
      end
      WRITEBACK: begin
        alu_src    = cls_alu_src;
        alu_op     = cls_alu_op;
        imm_src    = cls_imm_src;
        reg_write  = 1'b1;
        mem_to_reg = (op_class == C_LOAD);
        instr_done = 1'b1;
        state_next = FETCH;
      end
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  // Reset masks every output combinationally so an in-flight memory strobe drops at once.
  assign bus.o_PCWrite    = pc_write   & ~i_rst;
  assign bus.o_IRWrite    = ir_write   & ~i_rst;
  assign bus.o_IorD       = i_or_d     & ~i_rst;
  assign bus.o_Jump       = jump       & ~i_rst;
  assign bus.o_ALUSrc     = alu_src    & ~i_rst;
  assign bus.o_MemtoReg   = mem_to_reg & ~i_rst;
  assign bus.o_RegWrite   = reg_write  & ~i_rst;
  assign bus.o_MemRead    = mem_read   & ~i_rst;
  assign bus.o_MemWrite   = mem_write  & ~i_rst;
  assign bus.o_Branch     = branch     & ~i_rst;
  assign bus.o_ALUOp      = i_rst ? 2'b00 : alu_op;
  assign bus.o_ImmSrc     = i_rst ? 3'b000 : imm_src;
  assign bus.o_state      = i_rst ? 3'd0 : state;
  assign bus.o_instr_done = instr_done & ~i_rst;
`ifdef ILLEGAL_OP_EN
  assign bus.o_illegal    = illegal_q & ~i_rst;
`else
  assign bus.o_illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: vector table, hand-written corner sequences and
// random stimulus against a phase-list reference model.
module tb_multicycle_control;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

`ifdef ILLEGAL_OP_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  typedef struct packed {
    logic       pcw, irw, iord, jump, alusrc, m2r, rw, mr, mw, br;
    logic [1:0] aluop;
    logic [2:0] imm;
    logic [2:0] st;
    logic       done, ill;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       rdy;
    outs_t      exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if bus ();
  multicycle_control dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int unsigned applied = 0;
  int unsigned miscompares = 0;
  outs_t got;

  // Reference model: each instruction is a list of spec state numbers it visits.
  int unsigned path[$];
  int unsigned pos;
  logic [6:0]  mop;
  logic        m_ill;

  function automatic outs_t klass(input logic [6:0] op);
    outs_t c = '0;
    case (op)
      OP_R:     c.aluop = 2'b10;
      OP_I:     begin c.alusrc = 1'b1; c.aluop = 2'b10; end
      OP_LD:    c.alusrc = 1'b1;
      OP_ST:    begin c.alusrc = 1'b1; c.imm = 3'b001; end
      OP_BR:    begin c.br = 1'b1; c.aluop = 2'b01; c.imm = 3'b010; end
      OP_JAL:   begin c.imm = 3'b011; c.jump = 1'b1; end
      OP_JALR:  begin c.alusrc = 1'b1; c.jump = 1'b1; end
      OP_AUIPC: begin c.alusrc = 1'b1; c.imm = 3'b100; end
      default:  ;
    endcase
    return c;
  endfunction

  function automatic void fresh_path();
    path.delete();
    path.push_back(0);
    path.push_back(1);
    pos = 0;
  endfunction

  function automatic void m_reset();
    fresh_path();
    mop   = '0;
    m_ill = 1'b0;
  endfunction

  function automatic void new_path(input logic [6:0] op);
    path.delete();
    path.push_back(0); path.push_back(1); path.push_back(2);
    case (op)
      OP_LD:  begin path.push_back(3); path.push_back(4); end
      OP_ST:  path.push_back(3);
      OP_BR:  ;
      OP_R, OP_I, OP_JAL, OP_JALR, OP_AUIPC: path.push_back(4);
      default: if (ILL_EN) path.push_back(5);
    endcase
  endfunction

  function automatic outs_t m_expect(input logic r, input logic rd);
    outs_t e = '0;
    outs_t c;
    int unsigned ph;
    if (r) return e;
    ph    = path[pos];
    e.st  = 3'(ph);
    e.ill = m_ill;
    c     = klass(mop);
    case (ph)
      0: begin e.mr = 1'b1; e.irw = rd; e.pcw = rd; end
      2: begin
        e.alusrc = c.alusrc; e.aluop = c.aluop; e.imm = c.imm;
        e.br = c.br; e.jump = c.jump; e.pcw = c.jump;
        e.done = (pos == path.size() - 1);
      end
      3: begin
        e.alusrc = c.alusrc; e.aluop = c.aluop; e.imm = c.imm;
        e.iord = 1'b1;
        e.mr   = (mop == OP_LD);
        e.mw   = (mop == OP_ST);
        e.done = (mop == OP_ST) && rd;
      end
      4: begin
        e.alusrc = c.alusrc; e.aluop = c.aluop; e.imm = c.imm;
        e.rw = 1'b1; e.m2r = (mop == OP_LD); e.done = 1'b1;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic void m_advance(input logic r, input logic rd, input logic [6:0] op);
    int unsigned ph;
    if (r) begin m_reset(); return; end
    ph = path[pos];
    if (ph == 5 || ((ph == 0 || ph == 3) && !rd)) return;
    if (ph == 1) begin mop = op; new_path(op); end
    pos++;
    if (pos >= path.size()) fresh_path();
    else if (path[pos] == 5) m_ill = 1'b1;
  endfunction

  function automatic outs_t sample();
    outs_t s;
    s.pcw = bus.o_PCWrite;   s.irw = bus.o_IRWrite;  s.iord = bus.o_IorD;
    s.jump = bus.o_Jump;     s.alusrc = bus.o_ALUSrc; s.m2r = bus.o_MemtoReg;
    s.rw = bus.o_RegWrite;   s.mr = bus.o_MemRead;   s.mw = bus.o_MemWrite;
    s.br = bus.o_Branch;     s.aluop = bus.o_ALUOp;  s.imm = bus.o_ImmSrc;
    s.st = bus.o_state;      s.done = bus.o_instr_done; s.ill = bus.o_illegal;
    return s;
  endfunction

  function automatic outs_t o(input int st, pcw, irw, mr, mw, iord, alusrc, m2r,
                              rw, br, aluop, imm, done);
    outs_t e = '0;
    e.st = 3'(st); e.pcw = 1'(pcw); e.irw = 1'(irw); e.mr = 1'(mr); e.mw = 1'(mw);
    e.iord = 1'(iord); e.alusrc = 1'(alusrc); e.m2r = 1'(m2r); e.rw = 1'(rw);
    e.br = 1'(br); e.aluop = 2'(aluop); e.imm = 3'(imm); e.done = 1'(done);
    return e;
  endfunction

  function automatic vec_t v(input int r, input logic [6:0] op, input int rd, input outs_t e);
    vec_t x;
    x.rst = 1'(r); x.op = op; x.rdy = 1'(rd); x.exp = e;
    return x;
  endfunction

  task automatic cmp(input string nm, input outs_t a, input outs_t e);
    applied++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h required %h (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic chk(input string nm, input int unsigned a, input int unsigned e);
    applied++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic apply(input logic r, input logic [6:0] op, input logic rd);
    rst = r;
    bus.i_opcode = op;
    bus.i_mem_ready = rd;
    @(negedge clk);
    got = sample();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    m_advance(rst, bus.i_mem_ready, bus.i_opcode);
  endtask

  task automatic step(input string nm, input logic r, input logic [6:0] op, input logic rd);
    apply(r, op, rd);
    cmp(nm, got, m_expect(r, rd));
    advance();
  endtask

  vec_t vecs[$];
  logic [6:0] pool [9] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_AUIPC, OP_BAD};

  initial begin
    int unsigned nmw;
    logic        r, rd;
    logic [6:0]  op;

    bus.i_opcode = OP_R;
    bus.i_mem_ready = 1'b1;
    m_reset();

    //            st pcw irw mr mw iord asrc m2r rw br aluop imm done
    vecs.push_back(v(1, OP_R,  1, o(0, 0,0,0,0,0,0,0,0,0,0,0,0)));
    vecs.push_back(v(0, OP_R,  1, o(0, 1,1,1,0,0,0,0,0,0,0,0,0)));
    vecs.push_back(v(0, OP_R,  1, o(1, 0,0,0,0,0,0,0,0,0,0,0,0)));
    vecs.push_back(v(0, OP_R,  1, o(2, 0,0,0,0,0,0,0,0,0,2,0,0)));
    vecs.push_back(v(0, OP_R,  1, o(4, 0,0,0,0,0,0,0,1,0,2,0,1)));
    vecs.push_back(v(0, OP_LD, 1, o(0, 1,1,1,0,0,0,0,0,0,0,0,0)));
    vecs.push_back(v(0, OP_LD, 1, o(1, 0,0,0,0,0,0,0,0,0,0,0,0)));
    vecs.push_back(v(0, OP_LD, 1, o(2, 0,0,0,0,0,1,0,0,0,0,0,0)));
    vecs.push_back(v(0, OP_LD, 0, o(3, 0,0,1,0,1,1,0,0,0,0,0,0)));
    vecs.push_back(v(0, OP_LD, 0, o(3, 0,0,1,0,1,1,0,0,0,0,0,0)));
    vecs.push_back(v(0, OP_LD, 1, o(3, 0,0,1,0,1,1,0,0,0,0,0,0)));
    vecs.push_back(v(0, OP_LD, 1, o(4, 0,0,0,0,0,1,1,1,0,0,0,1)));
    vecs.push_back(v(0, OP_ST, 0, o(0, 0,0,1,0,0,0,0,0,0,0,0,0)));
    vecs.push_back(v(0, OP_ST, 1, o(0, 1,1,1,0,0,0,0,0,0,0,0,0)));
    vecs.push_back(v(0, OP_ST, 1, o(1, 0,0,0,0,0,0,0,0,0,0,0,0)));
    vecs.push_back(v(0, OP_ST, 1, o(2, 0,0,0,0,0,1,0,0,0,0,1,0)));
    vecs.push_back(v(0, OP_ST, 1, o(3, 0,0,0,1,1,1,0,0,0,0,1,1)));
    vecs.push_back(v(0, OP_BR, 1, o(0, 1,1,1,0,0,0,0,0,0,0,0,0)));
    vecs.push_back(v(0, OP_BR, 1, o(1, 0,0,0,0,0,0,0,0,0,0,0,0)));
    vecs.push_back(v(0, OP_BR, 1, o(2, 0,0,0,0,0,0,0,0,1,1,2,1)));
    vecs.push_back(v(0, OP_R,  1, o(0, 1,1,1,0,0,0,0,0,0,0,0,0)));

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].op, vecs[i].rdy);
      cmp($sformatf("vec%0d", i), got, vecs[i].exp);
      advance();
    end

    // Reset lands on a store that is stalled in MEM.
    step("a_rst", 1'b1, OP_ST, 1'b1);
    step("a_f",   1'b0, OP_ST, 1'b1);
    step("a_d",   1'b0, OP_ST, 1'b1);
    step("a_e",   1'b0, OP_ST, 1'b1);
    apply(1'b0, OP_ST, 1'b0);
    chk("a_mem_mw", int'(got.mw), 1);
    chk("a_mem_st", int'(got.st), 3);
    cmp("a_mem", got, m_expect(1'b0, 1'b0));
    advance();
    apply(1'b1, OP_ST, 1'b0);
    chk("a_rst_mw", int'(got.mw), 0);
    cmp("a_rst", got, m_expect(1'b1, 1'b0));
    advance();
    apply(1'b0, OP_R, 1'b0);
    chk("a_restart_st", int'(got.st), 0);
    chk("a_restart_mr", int'(got.mr), 1);
    cmp("a_restart", got, m_expect(1'b0, 1'b0));
    advance();
    nmw = 0;
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, OP_R, 1'b1);
      if (got.mw === 1'b1) nmw++;
      cmp("a_after", got, m_expect(1'b0, 1'b1));
      advance();
    end
    chk("a_no_rewrite", nmw, 0);

    // Unrecognised opcode.
    step("b_rst", 1'b1, OP_BAD, 1'b1);
    step("b_f",   1'b0, OP_BAD, 1'b1);
    step("b_d",   1'b0, OP_BAD, 1'b1);
    apply(1'b0, OP_BAD, 1'b1);
`ifdef ILLEGAL_OP_EN
    chk("b_exec_done", int'(got.done), 0);
    cmp("b_exec", got, m_expect(1'b0, 1'b1));
    advance();
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, OP_R, 1'(i & 1));
      chk("b_halt_st", int'(got.st), 5);
      chk("b_illegal", int'(got.ill), 1);
      cmp("b_halt", got, m_expect(1'b0, 1'(i & 1)));
      advance();
    end
    apply(1'b1, OP_R, 1'b1);
    chk("b_rst_ill", int'(got.ill), 0);
    advance();
    apply(1'b0, OP_R, 1'b1);
    chk("b_after_rst_st", int'(got.st), 0);
    advance();
`else
    chk("b_nop_done", int'(got.done), 1);
    cmp("b_exec", got, m_expect(1'b0, 1'b1));
    advance();
    apply(1'b0, OP_R, 1'b1);
    chk("b_nop_back", int'(got.st), 0);
    chk("b_nop_ill", int'(got.ill), 0);
    cmp("b_back", got, m_expect(1'b0, 1'b1));
    advance();
`endif

    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : pool[$urandom_range(0, 8)];
      rd = ($urandom_range(0, 3) != 0);
      step($sformatf("rand%0d", i), r, op, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
